// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and defaults for the two-port memory arbiter.
//   state_t   : arbiter FSM states (IDLE / RD / WR)
//   port_id_t : requesting port identity (PORT_I = instruction, PORT_D = data)
//   DEF_ADDR_W / DEF_DATA_W : default byte-address and memory-word widths
// Build option: MEM_ARB_RR_EN selects round-robin arbitration (see mem_arb_pick).
// -----------------------------------------------------------------------------
package mem_arb_pkg;

  localparam int DEF_ADDR_W = 24;
  localparam int DEF_DATA_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } state_t;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_id_t;

endpackage

// File: rtl/mem_arb_pick.sv
// -----------------------------------------------------------------------------
// mem_arb_pick
// Combinational winner selection between the instruction and data ports.
// Build option MEM_ARB_RR_EN:
//   defined   : round-robin; on a tie the port not granted last wins. A
//               "last granted" pointer register is kept and updated on every
//               grant. It resets to PORT_I so the first tie goes to data.
//   undefined : fixed priority, data port wins. No state is built, so the
//               clock/reset/grant-enable ports are absent.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset (RR build only)
//   i_grant_en  : a grant is being issued this cycle (RR build only)
//   i_req_i     : instruction port request
//   i_req_d     : data port request
//   o_winner    : selected port (PORT_D when nobody requests; unused then)
// -----------------------------------------------------------------------------
module mem_arb_pick
  import mem_arb_pkg::*;
(
`ifdef MEM_ARB_RR_EN
  input  logic     clk,
  input  logic     rst,
  input  logic     i_grant_en,
`endif
  input  logic     i_req_i,
  input  logic     i_req_d,
  output port_id_t o_winner
);

`ifdef MEM_ARB_RR_EN
  port_id_t r_last;

  always_comb begin
    o_winner = PORT_D;
    if (i_req_i && i_req_d) begin
      o_winner = (r_last == PORT_D) ? PORT_I : PORT_D;
    end else if (i_req_i) begin
      o_winner = PORT_I;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last <= PORT_I;
    end else if (i_grant_en && (i_req_i || i_req_d)) begin
      r_last <= o_winner;
    end
  end
`else
  always_comb begin
    o_winner = PORT_D;
    if (i_req_i && !i_req_d) begin
      o_winner = PORT_I;
    end
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Arbitrates an instruction read port and a data read/write port onto one
// single-ported memory with a shared bidirectional data bus.
// A grant is issued combinationally in IDLE (memory access starts that cycle),
// then one RD or WR cycle follows using the registered request. Read data is
// captured at the end of RD and presented with a one-cycle rvalid pulse, so a
// read granted in cycle N returns in cycle N+2.
// Build option: MEM_ARB_RR_EN -> round-robin, otherwise data port has priority.
// Ports:
//   clk, rst                  : clock, asynchronous active-high reset
//   i_req/i_addr              : instruction read request, byte address
//   i_gnt/i_rvalid/i_rdata    : instruction grant, read-valid pulse, read word
//   d_req/d_we/d_addr         : data request, write enable, byte address
//   d_wdata/d_mask/d_shift    : write word, byte enables, shift (forwarded)
//   d_gnt/d_rvalid/d_rdata    : data grant, read-valid pulse, read word
//   mem_addr                  : memory word index (byte address >> 3)
//   mem_data                  : shared bus, driven only while writing
//   mem_mask/mem_shift        : write byte enables / shift to memory
//   mem_rw/mem_enable         : 1 = write / access active
// -----------------------------------------------------------------------------
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_gnt,
  output logic                i_rvalid,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_mask,
  input  logic [2:0]          d_shift,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic [ADDR_W-4:0]   mem_addr,
  inout  wire  [DATA_W-1:0]   mem_data,
  output logic [DATA_W/8-1:0] mem_mask,
  output logic [2:0]          mem_shift,
  output logic                mem_rw,
  output logic                mem_enable
);

  localparam int MASK_W = DATA_W / 8;

  state_t              r_state;
  state_t              w_state_next;
  port_id_t            r_port;
  logic [ADDR_W-4:0]   r_addr;
  logic [MASK_W-1:0]   r_mask;
  logic [2:0]          r_shift;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_i_rvalid;
  logic                r_d_rvalid;
  logic [DATA_W-1:0]   r_i_rdata;
  logic [DATA_W-1:0]   r_d_rdata;

  port_id_t            w_winner;
  logic                w_grant;
  logic                w_win_d;
  logic                w_win_we;
  logic [ADDR_W-4:0]   w_win_addr;
  logic                w_mem_en;
  logic                w_mem_rw;
  logic [ADDR_W-4:0]   w_mem_addr;
  logic [MASK_W-1:0]   w_mem_mask;
  logic [2:0]          w_mem_shift;
  logic [DATA_W-1:0]   w_wdata_out;

  // Byte-offset bits never reach a word-addressed memory.
  logic w_unused;
  assign w_unused = ^{i_addr[2:0], d_addr[2:0]};

  mem_arb_pick u_pick (
`ifdef MEM_ARB_RR_EN
    .clk        (clk),
    .rst        (rst),
    .i_grant_en (w_grant),
`endif
    .i_req_i    (i_req),
    .i_req_d    (d_req),
    .o_winner   (w_winner)
  );

  // Grant is gated by rst so that an asynchronous reset silences the
  // combinational grant path immediately, even with requests held.
  assign w_grant    = (r_state == IDLE) && !rst && (i_req || d_req);
  assign w_win_d    = (w_winner == PORT_D);
  assign w_win_we   = w_win_d && d_we;
  assign w_win_addr = w_win_d ? d_addr[ADDR_W-1:3] : i_addr[ADDR_W-1:3];

  always_comb begin
    w_state_next = r_state;
    w_mem_en     = 1'b0;
    w_mem_rw     = 1'b0;
    w_mem_addr   = '0;
    w_mem_mask   = '0;
    w_mem_shift  = 3'd0;
    w_wdata_out  = r_wdata;
    case (r_state)
      IDLE: begin
        if (w_grant) begin
          w_mem_en   = 1'b1;
          w_mem_rw   = w_win_we;
          w_mem_addr = w_win_addr;
          // A write grant already presents rw=1, so the bus and byte
          // enables must carry the live request to keep the cycle coherent.
          if (w_win_we) begin
            w_mem_mask  = d_mask;
            w_mem_shift = d_shift;
            w_wdata_out = d_wdata;
          end
          w_state_next = w_win_we ? WR : RD;
        end
      end
      RD: begin
        w_mem_en     = 1'b1;
        w_mem_addr   = r_addr;
        w_state_next = IDLE;
      end
      WR: begin
        w_mem_en     = 1'b1;
        w_mem_rw     = 1'b1;
        w_mem_addr   = r_addr;
        w_mem_mask   = r_mask;
        w_mem_shift  = r_shift;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_port     <= PORT_I;
      r_addr     <= '0;
      r_mask     <= '0;
      r_shift    <= 3'd0;
      r_wdata    <= '0;
      r_i_rvalid <= 1'b0;
      r_d_rvalid <= 1'b0;
      r_i_rdata  <= '0;
      r_d_rdata  <= '0;
    end else begin
      r_state    <= w_state_next;
      r_i_rvalid <= 1'b0;
      r_d_rvalid <= 1'b0;
      if (w_grant) begin
        r_port  <= w_winner;
        r_addr  <= w_win_addr;
        r_mask  <= w_win_we ? d_mask : '0;
        r_shift <= w_win_d ? d_shift : 3'd0;
        r_wdata <= d_wdata;
      end
      if (r_state == RD) begin
        if (r_port == PORT_D) begin
          r_d_rvalid <= 1'b1;
          r_d_rdata  <= mem_data;
        end else begin
          r_i_rvalid <= 1'b1;
          r_i_rdata  <= mem_data;
        end
      end
    end
  end

  assign mem_data   = (w_mem_en && w_mem_rw) ? w_wdata_out : 'z;
  assign mem_enable = w_mem_en;
  assign mem_rw     = w_mem_rw;
  assign mem_addr   = w_mem_addr;
  assign mem_mask   = w_mem_mask;
  assign mem_shift  = w_mem_shift;

  assign i_gnt      = w_grant && !w_win_d;
  assign d_gnt      = w_grant && w_win_d;
  assign i_rvalid   = r_i_rvalid;
  assign d_rvalid   = r_d_rvalid;
  assign i_rdata    = r_i_rdata;
  assign d_rdata    = r_d_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Directed bench for mem_arbiter with a small byte-masked memory model on the
// shared bus. Expected arbitration order follows MEM_ARB_RR_EN.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int ADDR_W = 24;
  localparam int DATA_W = 64;

  logic              clk;
  logic              rst;
  logic              i_req;
  logic [23:0]       i_addr;
  logic              i_gnt;
  logic              i_rvalid;
  logic [63:0]       i_rdata;
  logic              d_req;
  logic              d_we;
  logic [23:0]       d_addr;
  logic [63:0]       d_wdata;
  logic [7:0]        d_mask;
  logic [2:0]        d_shift;
  logic              d_gnt;
  logic              d_rvalid;
  logic [63:0]       d_rdata;
  logic [20:0]       mem_addr;
  wire  [63:0]       mem_data;
  logic [7:0]        mem_mask;
  logic [2:0]        mem_shift;
  logic              mem_rw;
  logic              mem_enable;

  int n_checks = 0;
  int n_fail   = 0;

  // Memory model: drives the bus during read accesses, byte-masked writes.
  logic [63:0] mem [0:31];
  logic        pre_we;
  logic [4:0]  pre_idx;
  logic [63:0] pre_val;

  assign mem_data = (mem_enable && !mem_rw) ? mem[mem_addr[4:0]] : 'z;

  always @(posedge clk) begin
    if (pre_we) begin
      mem[pre_idx] <= pre_val;
    end else if (mem_enable && mem_rw) begin
      for (int b = 0; b < 8; b++) begin
        if (mem_mask[b]) mem[mem_addr[4:0]][8*b +: 8] <= mem_data[8*b +: 8];
      end
    end
  end

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_req      (i_req),
    .i_addr     (i_addr),
    .i_gnt      (i_gnt),
    .i_rvalid   (i_rvalid),
    .i_rdata    (i_rdata),
    .d_req      (d_req),
    .d_we       (d_we),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_mask     (d_mask),
    .d_shift    (d_shift),
    .d_gnt      (d_gnt),
    .d_rvalid   (d_rvalid),
    .d_rdata    (d_rdata),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .mem_mask   (mem_mask),
    .mem_shift  (mem_shift),
    .mem_rw     (mem_rw),
    .mem_enable (mem_enable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic preload(input logic [4:0] idx, input logic [63:0] val);
    @(posedge clk); #1;
    pre_we = 1'b1; pre_idx = idx; pre_val = val;
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    n_checks++; if (i_gnt !== 1'b0 || d_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_gnt: i=%b d=%b, want 0/0", i_gnt, d_gnt); end
    n_checks++; if (i_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid: i=%b d=%b, want 0/0", i_rvalid, d_rvalid); end
    n_checks++; if (i_rdata !== 64'h0 || d_rdata !== 64'h0) begin n_fail++; $display("FAIL reset_rdata: i=%h d=%h, want 0", i_rdata, d_rdata); end
    n_checks++; if (mem_enable !== 1'b0 || mem_rw !== 1'b0 || mem_mask !== 8'h00) begin n_fail++; $display("FAIL reset_mem: en=%b rw=%b mask=%h, want 0", mem_enable, mem_rw, mem_mask); end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    n_checks++; if (mem_enable !== 1'b0) begin n_fail++; $display("FAIL idle_enable: got %b, want 0", mem_enable); end
    $display("reset: done");
  endtask

  task automatic test_inst_read;
    preload(5'd2, 64'hDEADBEEF_CAFEF00D);
    i_req = 1'b1; i_addr = 24'h000010;
    #1;
    n_checks++; if (i_gnt !== 1'b1 || d_gnt !== 1'b0) begin n_fail++; $display("FAIL ird_gnt: i=%b d=%b, want 1/0", i_gnt, d_gnt); end
    n_checks++; if (mem_enable !== 1'b1 || mem_rw !== 1'b0 || mem_addr !== 21'd2) begin n_fail++; $display("FAIL ird_grant_bus: en=%b rw=%b addr=%0d, want 1/0/2", mem_enable, mem_rw, mem_addr); end
    @(posedge clk); #1;
    i_req = 1'b0; i_addr = 24'h0000F8;
    #1;
    n_checks++; if (mem_enable !== 1'b1 || mem_rw !== 1'b0 || mem_addr !== 21'd2) begin n_fail++; $display("FAIL ird_rd_bus: en=%b rw=%b addr=%0d, want 1/0/2", mem_enable, mem_rw, mem_addr); end
    n_checks++; if (i_rvalid !== 1'b0 || i_gnt !== 1'b0) begin n_fail++; $display("FAIL ird_rd_early: rvalid=%b gnt=%b, want 0/0", i_rvalid, i_gnt); end
    @(posedge clk); #1;
    n_checks++; if (i_rvalid !== 1'b1) begin n_fail++; $display("FAIL ird_rvalid: got %b, want 1", i_rvalid); end
    n_checks++; if (i_rdata !== 64'hDEADBEEF_CAFEF00D) begin n_fail++; $display("FAIL ird_rdata: got %h, want deadbeefcafef00d", i_rdata); end
    n_checks++; if (d_rvalid !== 1'b0 || mem_enable !== 1'b0) begin n_fail++; $display("FAIL ird_after: d_rvalid=%b en=%b, want 0/0", d_rvalid, mem_enable); end
    @(posedge clk); #1;
    n_checks++; if (i_rvalid !== 1'b0) begin n_fail++; $display("FAIL ird_pulse: got %b, want 0", i_rvalid); end
    $display("inst read: addr=0x10 data=%h", i_rdata);
  endtask

  task automatic test_write_read;
    preload(5'd4, 64'hAAAABBBB_CCCCDDDD);
    d_req = 1'b1; d_we = 1'b1; d_addr = 24'h000020;
    d_mask = 8'h0F; d_wdata = 64'h11223344_55667788; d_shift = 3'd2;
    #1;
    n_checks++; if (d_gnt !== 1'b1 || i_gnt !== 1'b0) begin n_fail++; $display("FAIL wr_gnt: d=%b i=%b, want 1/0", d_gnt, i_gnt); end
    n_checks++; if (mem_enable !== 1'b1 || mem_rw !== 1'b1 || mem_addr !== 21'd4) begin n_fail++; $display("FAIL wr_grant_bus: en=%b rw=%b addr=%0d, want 1/1/4", mem_enable, mem_rw, mem_addr); end
    n_checks++; if (mem_data !== 64'h11223344_55667788) begin n_fail++; $display("FAIL wr_grant_data: got %h, want 1122334455667788", mem_data); end
    @(posedge clk); #1;
    // Change live inputs: the WR cycle must use the registered copies.
    d_req = 1'b0; d_we = 1'b0; d_wdata = 64'hFFFFFFFF_FFFFFFFF; d_mask = 8'hFF; d_shift = 3'd5;
    #1;
    n_checks++; if (mem_enable !== 1'b1 || mem_rw !== 1'b1 || mem_addr !== 21'd4) begin n_fail++; $display("FAIL wr_cyc_bus: en=%b rw=%b addr=%0d, want 1/1/4", mem_enable, mem_rw, mem_addr); end
    n_checks++; if (mem_data !== 64'h11223344_55667788) begin n_fail++; $display("FAIL wr_cyc_data: got %h, want 1122334455667788", mem_data); end
    n_checks++; if (mem_mask !== 8'h0F || mem_shift !== 3'd2) begin n_fail++; $display("FAIL wr_cyc_ctl: mask=%h shift=%0d, want 0f/2", mem_mask, mem_shift); end
    @(posedge clk); #1;
    n_checks++; if (mem_enable !== 1'b0 || mem_rw !== 1'b0) begin n_fail++; $display("FAIL wr_done: en=%b rw=%b, want 0/0", mem_enable, mem_rw); end
    d_req = 1'b1; d_we = 1'b0; d_addr = 24'h000020; d_mask = 8'h00;
    #1;
    n_checks++; if (d_gnt !== 1'b1 || mem_rw !== 1'b0) begin n_fail++; $display("FAIL drd_gnt: gnt=%b rw=%b, want 1/0", d_gnt, mem_rw); end
    @(posedge clk); #1;
    d_req = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (d_rvalid !== 1'b1 || i_rvalid !== 1'b0) begin n_fail++; $display("FAIL drd_rvalid: d=%b i=%b, want 1/0", d_rvalid, i_rvalid); end
    n_checks++; if (d_rdata !== 64'hAAAABBBB_55667788) begin n_fail++; $display("FAIL drd_rdata: got %h, want aaaabbbb55667788", d_rdata); end
    $display("write+read: addr=0x20 mask=0f data=%h", d_rdata);
  endtask

  task automatic test_reset_mid_rd;
    @(posedge clk); #1;
    i_req = 1'b1; i_addr = 24'h000010;
    @(posedge clk); #1;
    n_checks++; if (mem_enable !== 1'b1 || i_gnt !== 1'b0) begin n_fail++; $display("FAIL rrd_in_rd: en=%b gnt=%b, want 1/0", mem_enable, i_gnt); end
    rst = 1'b1;
    #1;
    n_checks++; if (mem_enable !== 1'b0 || mem_rw !== 1'b0 || mem_mask !== 8'h00) begin n_fail++; $display("FAIL rrd_mem: en=%b rw=%b mask=%h, want 0", mem_enable, mem_rw, mem_mask); end
    n_checks++; if (i_gnt !== 1'b0 || d_gnt !== 1'b0) begin n_fail++; $display("FAIL rrd_gnt: i=%b d=%b, want 0/0", i_gnt, d_gnt); end
    n_checks++; if (i_rdata !== 64'h0 || d_rdata !== 64'h0) begin n_fail++; $display("FAIL rrd_rdata: i=%h d=%h, want 0", i_rdata, d_rdata); end
    i_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      n_checks++; if (i_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin n_fail++; $display("FAIL rrd_no_rvalid: cycle %0d i=%b d=%b, want 0/0", c, i_rvalid, d_rvalid); end
      @(posedge clk); #1;
    end
    d_req = 1'b1; d_we = 1'b0; d_addr = 24'h000020;
    #1;
    n_checks++; if (d_gnt !== 1'b1) begin n_fail++; $display("FAIL rrd_regrant: got %b, want 1", d_gnt); end
    @(posedge clk); #1;
    d_req = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (d_rvalid !== 1'b1 || d_rdata !== 64'hAAAABBBB_55667788) begin n_fail++; $display("FAIL rrd_reread: rvalid=%b data=%h, want 1/aaaabbbb55667788", d_rvalid, d_rdata); end
    $display("reset in RD: aborted, re-read data=%h", d_rdata);
  endtask

  task automatic test_both_requesting;
    logic found;
    logic got_d;
    logic want_d;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    i_req = 1'b1; i_addr = 24'h000010;
    d_req = 1'b1; d_we = 1'b0; d_addr = 24'h000020;
    #1;
    for (int k = 0; k < 4; k++) begin
      found = 1'b0;
      got_d = 1'b0;
      for (int c = 0; c < 8 && !found; c++) begin
        if (i_gnt || d_gnt) begin
          found = 1'b1;
          got_d = d_gnt;
          n_checks++; if ((i_gnt & d_gnt) !== 1'b0) begin n_fail++; $display("FAIL both_one_gnt: i=%b d=%b, want one", i_gnt, d_gnt); end
        end else begin
          @(posedge clk); #2;
        end
      end
`ifdef MEM_ARB_RR_EN
      want_d = (k % 2 == 0);
`else
      want_d = 1'b1;
`endif
      n_checks++;
      if (!found) begin
        n_fail++; $display("FAIL both_timeout: grant %0d not seen", k);
      end else if (got_d !== want_d) begin
        n_fail++; $display("FAIL both_order: grant %0d went to %s, want %s", k, got_d ? "D" : "I", want_d ? "D" : "I");
      end
      $display("both: grant %0d -> %s", k, got_d ? "D" : "I");
      @(posedge clk); #2;
    end
    i_req = 1'b0; d_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0;
    d_wdata = '0; d_mask = '0; d_shift = '0;
    pre_we = 1'b0; pre_idx = '0; pre_val = '0;
    test_reset();
    test_inst_read();
    test_write_read();
    test_reset_mid_rd();
    test_both_requesting();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1, "watchdog");
  end

endmodule
